// File: rtl/spike_cmd_pkg.sv
// Shared constants and state types for the spike command scheduler.
package spike_cmd_pkg;

  localparam logic [7:0] OpSetWidth  = 8'h01;
  localparam logic [7:0] OpSetFreq   = 8'h02;
  localparam logic [7:0] OpSetCount  = 8'h03;
  localparam logic [7:0] OpSetBursts = 8'h04;
  localparam logic [7:0] OpSetGap    = 8'h05;
  localparam logic [7:0] OpStart     = 8'h06;
  localparam logic [7:0] OpStop      = 8'h07;

  localparam logic [1:0] FldWidth = 2'b01;
  localparam logic [1:0] FldFreq  = 2'b10;
  localparam logic [1:0] FldCnt   = 2'b11;

  localparam logic [7:0] AckByte     = 8'h06;
  localparam logic [7:0] NakByte     = 8'h15;
  localparam logic [7:0] SilenceByte = 8'h8F;

  typedef enum logic [1:0] {PHdr, POp, PArg, PChk} parse_state_e;

  typedef enum logic [2:0] {SIdle, SWrW, SWrF, SWrC, SGap, SStop} seq_state_e;

  // Opcode/argument legality; checksum is validated separately.
  function automatic logic cmd_ok(input logic [7:0] op, input logic [7:0] arg);
    case (op)
      OpSetWidth, OpSetCount, OpSetBursts, OpSetGap: return 1'b1;
      OpSetFreq:                                     return arg[3:0] != 4'd0;
      OpStart, OpStop:                               return arg == 8'd0;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spike_cmd_parser.sv
// Frame parser: HDR, OP, ARG, CHK with inter-byte timeout, ACK/NAK response
// and a saturating count of rejected frames.
module spike_cmd_parser
  import spike_cmd_pkg::*;
#(
  parameter logic [7:0]  Hdr     = 8'hA5,
  parameter int unsigned Timeout = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_op_o,
  output logic [7:0] cmd_arg_o,
  output logic [7:0] resp_data_o,
  output logic       resp_valid_o,
  output logic [7:0] err_cnt_o
);

  localparam int unsigned TimerW = $clog2(Timeout + 1);

  parse_state_e      state_q, state_d;
  logic [7:0]        op_q, op_d, arg_q, arg_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              timed_out, reject;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    err_cnt_d    = err_cnt_q;
    cmd_valid_o  = 1'b0;
    reject       = 1'b0;
    // timer_q counts idle cycles minus one, so this fires on idle cycle Timeout+1
    timed_out    = (state_q != PHdr) && !rx_valid_i && (timer_q == TimerW'(Timeout));
    timer_d      = (rx_valid_i || state_q == PHdr || timed_out) ? '0 : timer_q + TimerW'(1);

    unique case (state_q)
      PHdr: if (rx_valid_i && rx_data_i == Hdr) state_d = POp;
      POp: begin
        if (rx_valid_i) begin
          op_d    = rx_data_i;
          state_d = PArg;
        end
      end
      PArg: begin
        if (rx_valid_i) begin
          arg_d   = rx_data_i;
          state_d = PChk;
        end
      end
      PChk: begin
        if (rx_valid_i) begin
          state_d = PHdr;
          if (cmd_ok(op_q, arg_q) && rx_data_i == (op_q ^ arg_q)) begin
            cmd_valid_o  = 1'b1;
            resp_valid_d = 1'b1;
            resp_data_d  = AckByte;
          end else begin
            reject = 1'b1;
          end
        end
      end
      default: state_d = PHdr;
    endcase

    if (timed_out) begin
      state_d = PHdr;
      reject  = 1'b1;
    end

    if (reject) begin
      resp_valid_d = 1'b1;
      resp_data_d  = NakByte;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PHdr;
      op_q         <= '0;
      arg_q        <= '0;
      timer_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      timer_q      <= timer_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign cmd_op_o     = op_q;
  assign cmd_arg_o    = arg_q;
  assign resp_data_o  = resp_data_q;
  assign resp_valid_o = resp_valid_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: rtl/spike_cmd_scheduler.sv
// Shadow pulse settings and burst sequencer driving the spike generator's
// single-byte config interface.
module spike_cmd_scheduler
  import spike_cmd_pkg::*;
#(
  parameter logic [7:0]  Hdr         = 8'hA5,
  parameter int unsigned CfgGap      = 16,
  parameter int unsigned Timeout     = 1_000_000,
  parameter int unsigned GapUnitLog2 = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cfg_byte,
  output logic       cfg_strobe,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int unsigned HoldW = $clog2(CfgGap);
  localparam int unsigned GapW  = 8 + GapUnitLog2;

  logic       cmd_valid;
  logic [7:0] cmd_op, cmd_arg;

  spike_cmd_parser #(
    .Hdr     (Hdr),
    .Timeout (Timeout)
  ) u_parser (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .cmd_valid_o  (cmd_valid),
    .cmd_op_o     (cmd_op),
    .cmd_arg_o    (cmd_arg),
    .resp_data_o  (resp_data),
    .resp_valid_o (resp_valid),
    .err_cnt_o    (err_cnt)
  );

  logic [5:0]      width_q, width_d, count_q, count_d;
  logic [3:0]      freq_q, freq_d;
  logic [7:0]      bursts_q, bursts_d, gap_q, gap_d;
  logic [5:0]      run_width_q, run_width_d, run_count_q, run_count_d;
  logic [3:0]      run_freq_q, run_freq_d;
  logic [7:0]      run_gap_q, run_gap_d, remaining_q, remaining_d;
  logic            run_cont_q, run_cont_d;
  seq_state_e      state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GapW-1:0] gap_tmr_q, gap_tmr_d;
  logic [7:0]      cfg_byte_q, cfg_byte_d;
  logic            cfg_strobe_q, cfg_strobe_d;
  logic            start, stop, issue;
  logic [7:0]      issue_byte;

  assign start = cmd_valid && cmd_op == OpStart;
  assign stop  = cmd_valid && cmd_op == OpStop;

  always_comb begin
    width_d     = width_q;
    freq_d      = freq_q;
    count_d     = count_q;
    bursts_d    = bursts_q;
    gap_d       = gap_q;
    run_width_d = run_width_q;
    run_freq_d  = run_freq_q;
    run_count_d = run_count_q;
    run_gap_d   = run_gap_q;
    run_cont_d  = run_cont_q;
    remaining_d = remaining_q;
    state_d     = state_q;
    gap_tmr_d   = gap_tmr_q;
    hold_d      = (hold_q != '0) ? hold_q - HoldW'(1) : '0;
    issue       = 1'b0;
    issue_byte  = cfg_byte_q;

    if (cmd_valid) begin
      case (cmd_op)
        OpSetWidth:  width_d  = cmd_arg[5:0];
        OpSetFreq:   freq_d   = cmd_arg[3:0];
        OpSetCount:  count_d  = cmd_arg[5:0];
        OpSetBursts: bursts_d = cmd_arg;
        OpSetGap:    gap_d    = cmd_arg;
        default: ;
      endcase
    end

    // hold_q spaces every strobe, independent of the sequencer state
    unique case (state_q)
      SIdle: begin
        if (stop) begin
          state_d = SStop;
        end else if (start) begin
          state_d     = SWrW;
          run_width_d = width_q;
          run_freq_d  = freq_q;
          run_count_d = count_q;
          run_gap_d   = gap_q;
          run_cont_d  = (bursts_q == 8'd0);
          remaining_d = bursts_q;
        end
      end
      SWrW: begin
        if (hold_q == '0) begin
          issue      = 1'b1;
          issue_byte = {FldWidth, run_width_q};
          state_d    = SWrF;
        end
      end
      SWrF: begin
        if (hold_q == '0) begin
          issue      = 1'b1;
          issue_byte = {FldFreq, 2'b00, run_freq_q};
          state_d    = SWrC;
        end
      end
      SWrC: begin
        if (hold_q == '0) begin
          issue       = 1'b1;
          issue_byte  = {FldCnt, run_count_q};
          remaining_d = remaining_q - 8'd1;
          if (!run_cont_q && remaining_q == 8'd1) begin
            state_d = SIdle;
          end else begin
            state_d   = SGap;
            gap_tmr_d = GapW'(run_gap_q) << GapUnitLog2;
          end
        end
      end
      SGap: begin
        // Exit two cycles early so the next count strobe lands exactly one gap later
        if (gap_tmr_q <= GapW'(2)) state_d = SWrC;
        else gap_tmr_d = gap_tmr_q - GapW'(1);
      end
      SStop: begin
        if (hold_q == '0) begin
          issue      = 1'b1;
          issue_byte = SilenceByte;
          state_d    = SIdle;
        end
      end
      default: state_d = SIdle;
    endcase

    if (state_q != SIdle && state_q != SStop && (stop || start)) state_d = SStop;

    cfg_strobe_d = issue;
    cfg_byte_d   = issue_byte;
    if (issue) hold_d = HoldW'(CfgGap - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q      <= '0;
      freq_q       <= 4'd15;
      count_q      <= '0;
      bursts_q     <= 8'd1;
      gap_q        <= '0;
      run_width_q  <= '0;
      run_freq_q   <= '0;
      run_count_q  <= '0;
      run_gap_q    <= '0;
      run_cont_q   <= 1'b0;
      remaining_q  <= '0;
      state_q      <= SIdle;
      hold_q       <= '0;
      gap_tmr_q    <= '0;
      cfg_byte_q   <= '0;
      cfg_strobe_q <= 1'b0;
    end else begin
      width_q      <= width_d;
      freq_q       <= freq_d;
      count_q      <= count_d;
      bursts_q     <= bursts_d;
      gap_q        <= gap_d;
      run_width_q  <= run_width_d;
      run_freq_q   <= run_freq_d;
      run_count_q  <= run_count_d;
      run_gap_q    <= run_gap_d;
      run_cont_q   <= run_cont_d;
      remaining_q  <= remaining_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      gap_tmr_q    <= gap_tmr_d;
      cfg_byte_q   <= cfg_byte_d;
      cfg_strobe_q <= cfg_strobe_d;
    end
  end

  assign cfg_byte   = cfg_byte_q;
  assign cfg_strobe = cfg_strobe_q;
  // Covers the final write cycle so busy drops only after the last strobe
  assign busy       = (state_q != SIdle) || cfg_strobe_q;

endmodule

// File: tb/tb_spike_cmd_scheduler.sv
// Directed bench for spike_cmd_scheduler with short timeout and gap unit.
module tb_spike_cmd_scheduler;

  localparam int unsigned CfgGap = 16;
  localparam int unsigned Tmo    = 100;
  localparam int unsigned GapLog = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] cfg_byte, resp_data, err_cnt;
  logic       cfg_strobe, resp_valid, busy;

  spike_cmd_scheduler #(
    .Hdr         (8'hA5),
    .CfgGap      (CfgGap),
    .Timeout     (Tmo),
    .GapUnitLog2 (GapLog)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cfg_byte   (cfg_byte),
    .cfg_strobe (cfg_strobe),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] strobe_q[$];
  int         strobe_cyc[$];
  logic [7:0] resp_q[$];
  int         last_strobe = -1000;
  int         exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Collect strobes/responses and police the strobe spacing
  always @(negedge clk) begin
    if (cfg_strobe) begin
      checks++;
      if (cyc - last_strobe < int'(CfgGap)) begin
        errors++;
        $display("FAIL strobe_spacing actual=%0d expected>=%0d", cyc - last_strobe, CfgGap);
      end
      last_strobe = cyc;
      strobe_q.push_back(cfg_byte);
      strobe_cyc.push_back(cyc);
    end
    if (resp_valid) resp_q.push_back(resp_data);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(arg);
    send_byte(chk);
  endtask

  task automatic do_frame(input string name, input logic [7:0] op, input logic [7:0] arg,
                          input logic [7:0] chk, input logic [7:0] exp_resp);
    int n0;
    n0 = resp_q.size();
    send_frame(op, arg, chk);
    idle(3);
    if (exp_resp == 8'h15) exp_err++;
    check({name, "_resp_cnt"}, resp_q.size(), n0 + 1);
    if (resp_q.size() > 0) check({name, "_resp"}, resp_q[$], exp_resp);
    check({name, "_err_cnt"}, err_cnt, exp_err);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (strobe_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    idle(1);
    check("strobe_wait", strobe_q.size() >= n, 1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] chk;
    logic [7:0] resp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0;
    int n1;
    vecs[0] = '{"set_width5", 8'h01, 8'h05, 8'h04, 8'h06};
    vecs[1] = '{"set_freq7",  8'h02, 8'h07, 8'h05, 8'h06};
    vecs[2] = '{"set_count3", 8'h03, 8'h03, 8'h00, 8'h06};
    vecs[3] = '{"bad_chk",    8'h01, 8'h0A, 8'h00, 8'h15};
    vecs[4] = '{"freq_zero",  8'h02, 8'h00, 8'h02, 8'h15};
    vecs[5] = '{"bad_op",     8'h09, 8'h00, 8'h09, 8'h15};
    vecs[6] = '{"start_arg",  8'h06, 8'h01, 8'h07, 8'h15};

    idle(3);
    check("rst_cfg_byte", cfg_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_data", resp_data, 8'h00);
    check("rst_err_cnt", err_cnt, 8'h00);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) do_frame(vecs[i].name, vecs[i].op, vecs[i].arg, vecs[i].chk, vecs[i].resp);

    // Single burst: width, freq, count; bad frame above must not have touched width
    n0 = strobe_q.size();
    send_frame(8'h06, 8'h00, 8'h06);
    check("start1_busy_rise", busy, 1'b1);
    wait_strobes(n0 + 3, 200);
    idle(3);
    check("start1_count", strobe_q.size(), n0 + 3);
    check("start1_w", strobe_q[n0], 8'h45);
    check("start1_f", strobe_q[n0+1], 8'h87);
    check("start1_c", strobe_q[n0+2], 8'hC3);
    check("start1_busy_fall", busy, 1'b0);
    check("start1_ack", resp_q[$], 8'h06);

    // Three bursts separated by one gap unit
    do_frame("set_bursts3", 8'h04, 8'h03, 8'h07, 8'h06);
    do_frame("set_gap1", 8'h05, 8'h01, 8'h04, 8'h06);
    n0 = strobe_q.size();
    send_frame(8'h06, 8'h00, 8'h06);
    wait_strobes(n0 + 5, 600);
    idle(150);
    check("burst3_count", strobe_q.size(), n0 + 5);
    check("burst3_c2", strobe_q[n0+3], 8'hC3);
    check("burst3_c3", strobe_q[n0+4], 8'hC3);
    check("burst3_gap1", strobe_cyc[n0+3] - strobe_cyc[n0+2], 1 << GapLog);
    check("burst3_gap2", strobe_cyc[n0+4] - strobe_cyc[n0+3], 1 << GapLog);
    check("burst3_busy", busy, 1'b0);

    // Timeout after exactly Tmo idle cycles is tolerated; Tmo+1 is not
    n0 = resp_q.size();
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(Tmo);
    send_byte(8'h05);
    send_byte(8'h04);
    idle(3);
    check("tmo_edge_resp", resp_q[$], 8'h06);
    check("tmo_edge_cnt", resp_q.size(), n0 + 1);
    n0 = resp_q.size();
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(Tmo + 1);
    send_byte(8'h05);
    send_byte(8'h04);
    idle(5);
    exp_err++;
    check("tmo_resp_cnt", resp_q.size(), n0 + 1);
    check("tmo_resp", resp_q[$], 8'h15);
    check("tmo_err_cnt", err_cnt, exp_err);

    // Continuous bursts, then STOP
    do_frame("set_bursts0", 8'h04, 8'h00, 8'h04, 8'h06);
    n0 = strobe_q.size();
    send_frame(8'h06, 8'h00, 8'h06);
    wait_strobes(n0 + 6, 600);
    check("cont_busy", busy, 1'b1);
    send_frame(8'h07, 8'h00, 8'h07);
    idle(100);
    check("stop_last", strobe_q[$], 8'h8F);
    check("stop_busy", busy, 1'b0);
    n1 = strobe_q.size();
    idle(150);
    check("stop_quiet", strobe_q.size(), n1);

    // STOP while idle still silences the generator
    n0 = strobe_q.size();
    send_frame(8'h07, 8'h00, 8'h07);
    idle(40);
    check("idle_stop_cnt", strobe_q.size(), n0 + 1);
    check("idle_stop_byte", strobe_q[$], 8'h8F);

    // Reset during the gap phase
    do_frame("set_bursts3b", 8'h04, 8'h03, 8'h07, 8'h06);
    n0 = strobe_q.size();
    send_frame(8'h06, 8'h00, 8'h06);
    wait_strobes(n0 + 3, 200);
    idle(10);
    check("gap_busy", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    check("arst_cfg_byte", cfg_byte, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_err_cnt", err_cnt, 8'h00);
    exp_err = 0;
    idle(2);
    rst_n = 1'b1;
    n1 = strobe_q.size();
    idle(200);
    check("post_rst_quiet", strobe_q.size(), n1);

    // Reset shadow values: width 0, freq 15, count 0, single burst
    send_frame(8'h06, 8'h00, 8'h06);
    wait_strobes(n1 + 3, 200);
    idle(100);
    check("rst_start_cnt", strobe_q.size(), n1 + 3);
    check("rst_start_w", strobe_q[n1], 8'h40);
    check("rst_start_f", strobe_q[n1+1], 8'h8F);
    check("rst_start_c", strobe_q[n1+2], 8'hC0);
    check("rst_start_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
